// File: rtl/result_collector_if.sv
// Valid/ready stream carrying one result row per beat from the DUT to the collector.
interface result_collector_if #(
    parameter int unsigned BW = 64
) ();
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/result_collector.sv
// Collects streamed result rows into a matrix and pulses start_cmp_o once it is complete.
// Also flags bad dimensions, in_last misplacement and stalled collections.
module result_collector #(
    parameter int unsigned BW          = 64,
    parameter int unsigned DW          = 16,
    parameter int unsigned MAX_DIM     = BW / DW,
    parameter int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned DimW       = $clog2(MAX_DIM) + 1,
    localparam int unsigned MatW       = MAX_DIM * MAX_DIM * DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm_i,
    input  logic [DimW-1:0]     n_dim_i,
    input  logic [DimW-1:0]     m_dim_i,
    result_collector_if.slave   in_if,
    output logic [MatW-1:0]     mat_res_flat_o,
    output logic                start_cmp_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                dim_err_o,
    output logic                last_err_o,
    output logic                timeout_err_o
);

    typedef enum logic [1:0] {StIdle, StCollect, StCmp, StDone} state_e;

    state_e            state_q, state_d;
    logic [DimW-1:0]   row_cnt_q, row_cnt_d;
    logic [DimW-1:0]   n_q, n_d;
    logic [DimW-1:0]   m_q, m_d;
    logic [31:0]       stall_q, stall_d;
    logic [MatW-1:0]   mat_q, mat_d;
    logic              in_ready_q;
    logic              dim_err_q, dim_err_d;
    logic              last_err_q, last_err_d;
    logic              timeout_err_q, timeout_err_d;

    logic              arm_take;
    logic              dims_ok;
    logic              is_final;

    assign dims_ok = (n_dim_i != '0) && (n_dim_i <= DimW'(MAX_DIM)) &&
                     (m_dim_i != '0) && (m_dim_i <= DimW'(MAX_DIM));
    // Arm is ignored only during the single CMP cycle.
    assign arm_take = arm_i && (state_q != StCmp);
    assign is_final = (row_cnt_q == n_q - DimW'(1));

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        n_d           = n_q;
        m_d           = m_q;
        stall_d       = stall_q;
        mat_d         = mat_q;
        dim_err_d     = dim_err_q;
        last_err_d    = last_err_q;
        timeout_err_d = timeout_err_q;

        if (arm_take) begin
            dim_err_d     = 1'b0;
            last_err_d    = 1'b0;
            timeout_err_d = 1'b0;
            if (!dims_ok) begin
                dim_err_d = 1'b1;
                state_d   = StIdle;
            end else begin
                n_d       = n_dim_i;
                m_d       = m_dim_i;
                mat_d     = '0;
                row_cnt_d = '0;
                stall_d   = '0;
                state_d   = StCollect;
            end
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (in_if.in_valid && in_ready_q) begin
                        for (int j = 0; j < int'(MAX_DIM); j++) begin
                            mat_d[(int'(row_cnt_q) * int'(MAX_DIM) + j) * int'(DW) +: DW] =
                                (j < int'(m_q)) ? in_if.in_data[j * int'(DW) +: DW] : '0;
                        end
                        row_cnt_d = row_cnt_q + DimW'(1);
                        stall_d   = '0;
                        if (in_if.in_last != is_final) begin
                            last_err_d = 1'b1;
                        end
                        if (is_final) begin
                            state_d = StCmp;
                        end
                    end else begin
                        stall_d = stall_q + 32'd1;
                        if ((TIMEOUT_CYC != 0) && (stall_d == TIMEOUT_CYC)) begin
                            timeout_err_d = 1'b1;
                            state_d       = StIdle;
                        end
                    end
                end
                StCmp:   state_d = StDone;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            row_cnt_q     <= '0;
            n_q           <= '0;
            m_q           <= '0;
            stall_q       <= '0;
            mat_q         <= '0;
            in_ready_q    <= 1'b0;
            dim_err_q     <= 1'b0;
            last_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            n_q           <= n_d;
            m_q           <= m_d;
            stall_q       <= stall_d;
            mat_q         <= mat_d;
            in_ready_q    <= (state_d == StCollect);
            dim_err_q     <= dim_err_d;
            last_err_q    <= last_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign mat_res_flat_o = mat_q;
    assign start_cmp_o    = (state_q == StCmp);
    assign busy_o         = (state_q == StCollect) || (state_q == StCmp);
    assign done_o         = (state_q == StDone);
    assign dim_err_o      = dim_err_q;
    assign last_err_o     = last_err_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: hand-computed matrices, flags and start_cmp pulse counts.
module tb_result_collector;

    localparam int unsigned BW = 64;
    localparam int unsigned DW = 16;
    localparam int unsigned MatW = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic [2:0]       n_dim;
    logic [2:0]       m_dim;
    logic [MatW-1:0]  mat;
    logic             start_cmp;
    logic             busy;
    logic             done;
    logic             dim_err;
    logic             last_err;
    logic             timeout_err;

    int               checks = 0;
    int               errors = 0;
    int               start_cnt = 0;
    int               start_base;
    logic [MatW-1:0]  exp_mat;

    result_collector_if #(.BW(BW)) s_if ();

    result_collector #(
        .BW          (BW),
        .DW          (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm_i         (arm),
        .n_dim_i       (n_dim),
        .m_dim_i       (m_dim),
        .in_if         (s_if.slave),
        .mat_res_flat_o(mat),
        .start_cmp_o   (start_cmp),
        .busy_o        (busy),
        .done_o        (done),
        .dim_err_o     (dim_err),
        .last_err_o    (last_err),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_cmp) start_cnt <= start_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [MatW-1:0] got,
                            input logic [MatW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_elem(input int i, input int j, input logic [15:0] v);
        exp_mat[(i * 4 + j) * 16 +: 16] = v;
    endtask

    task automatic do_arm(input logic [2:0] n, input logic [2:0] m);
        arm   = 1'b1;
        n_dim = n;
        m_dim = m;
        step();
        arm   = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic l);
        s_if.in_valid = 1'b1;
        s_if.in_data  = d;
        s_if.in_last  = l;
        step();
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        arm = 1'b0;
        n_dim = '0;
        m_dim = '0;
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        s_if.in_last  = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_ready", 256'(s_if.in_ready), 256'(0));
        check_eq("rst_flags", 256'({start_cmp, busy, done, dim_err, last_err, timeout_err}),
                 256'(0));
        check_eq("rst_mat", mat, '0);

        // Full-size 4x4, valid held high
        start_base = start_cnt;
        do_arm(3'd4, 3'd4);
        check_eq("t1_ready", 256'(s_if.in_ready), 256'(1));
        check_eq("t1_busy", 256'(busy), 256'(1));
        s_if.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_if.in_data = {16'(i * 4 + 3), 16'(i * 4 + 2), 16'(i * 4 + 1), 16'(i * 4)};
            s_if.in_last = (i == 3);
            step();
            if (i < 3) check_eq("t1_nostart", 256'(start_cmp), 256'(0));
        end
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
        check_eq("t1_start", 256'(start_cmp), 256'(1));
        check_eq("t1_m21", 256'(mat[(2 * 4 + 1) * 16 +: 16]), 256'(9));
        exp_mat = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) set_elem(i, j, 16'(i * 4 + j));
        check_eq("t1_mat", mat, exp_mat);
        step();
        check_eq("t1_done", 256'({done, start_cmp, s_if.in_ready}), 256'(3'b100));
        check_eq("t1_errs", 256'({dim_err, last_err, timeout_err}), 256'(0));
        check_eq("t1_pulses", 256'(start_cnt - start_base), 256'(1));

        // Partial width N=2 M=3 with a stall between beats
        start_base = start_cnt;
        do_arm(3'd2, 3'd3);
        check_eq("t2_cleared", mat, '0);
        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        check_eq("t2_mid", 256'({busy, start_cmp}), 256'(2'b10));
        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check_eq("t2_start", 256'(start_cmp), 256'(1));
        step();
        exp_mat = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) set_elem(i, j, 16'hFFFF);
        check_eq("t2_mat", mat, exp_mat);
        check_eq("t2_done", 256'({done, last_err}), 256'(2'b10));
        check_eq("t2_pulses", 256'(start_cnt - start_base), 256'(1));

        // Illegal dimensions leave the matrix alone
        start_base = start_cnt;
        do_arm(3'd0, 3'd4);
        check_eq("t3_dimerr_n", 256'({dim_err, busy, done, s_if.in_ready}), 256'(4'b1000));
        check_eq("t3_mat_kept", mat, exp_mat);
        step();
        check_eq("t3_ready_low", 256'(s_if.in_ready), 256'(0));
        do_arm(3'd4, 3'd5);
        check_eq("t3_dimerr_m", 256'({dim_err, busy, s_if.in_ready}), 256'(3'b100));
        step();
        check_eq("t3_pulses", 256'(start_cnt - start_base), 256'(0));

        // in_last early on row 1; collection still runs to N=3
        start_base = start_cnt;
        do_arm(3'd3, 3'd4);
        check_eq("t4_dim_clr", 256'(dim_err), 256'(0));
        beat(64'h0004_0003_0002_0001, 1'b0);
        check_eq("t4_no_err", 256'(last_err), 256'(0));
        beat(64'h0008_0007_0006_0005, 1'b1);
        check_eq("t4_last_err", 256'({last_err, busy}), 256'(2'b11));
        beat(64'h000C_000B_000A_0009, 1'b1);
        check_eq("t4_start", 256'(start_cmp), 256'(1));
        step();
        check_eq("t4_done", 256'(done), 256'(1));
        check_eq("t4_pulses", 256'(start_cnt - start_base), 256'(1));
        do_arm(3'd1, 3'd1);
        check_eq("t4_clr", 256'({last_err, busy}), 256'(2'b01));

        // Timeout: restart with N=4, one beat, then starve
        start_base = start_cnt;
        do_arm(3'd4, 3'd4);
        beat(64'h4444_3333_2222_1111, 1'b0);
        for (int k = 0; k < 7; k++) step();
        check_eq("t5_pre_to", 256'({busy, timeout_err}), 256'(2'b10));
        step();
        check_eq("t5_to", 256'({busy, timeout_err, s_if.in_ready, done}), 256'(4'b0100));
        exp_mat = '0;
        set_elem(0, 0, 16'h1111);
        set_elem(0, 1, 16'h2222);
        set_elem(0, 2, 16'h3333);
        set_elem(0, 3, 16'h4444);
        check_eq("t5_mat", mat, exp_mat);
        check_eq("t5_pulses", 256'(start_cnt - start_base), 256'(0));

        // Reset mid-collection
        do_arm(3'd4, 3'd4);
        beat(64'h0101_0101_0101_0101, 1'b0);
        beat(64'h0202_0202_0202_0202, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5_rst_out", 256'({s_if.in_ready, start_cmp, busy, done, dim_err, last_err,
                                     timeout_err}), 256'(0));
        check_eq("t5_rst_mat", mat, '0);

        // Re-arm during COLLECT with a beat offered in the arm cycle
        do_arm(3'd4, 3'd4);
        beat(64'h5555_5555_5555_5555, 1'b0);
        beat(64'h6666_6666_6666_6666, 1'b0);
        start_base = start_cnt;
        s_if.in_valid = 1'b1;
        s_if.in_data  = 64'h7777_7777_7777_7777;
        do_arm(3'd1, 3'd1);
        s_if.in_valid = 1'b0;
        check_eq("t6_rearm", 256'({busy, s_if.in_ready, start_cmp}), 256'(3'b110));
        check_eq("t6_zero", mat, '0);
        beat(64'hDEAD_BEEF_CAFE_00AB, 1'b1);
        check_eq("t6_start", 256'(start_cmp), 256'(1));
        step();
        exp_mat = '0;
        set_elem(0, 0, 16'h00AB);
        check_eq("t6_mat", mat, exp_mat);
        check_eq("t6_done", 256'({done, last_err}), 256'(2'b10));
        step();
        check_eq("t6_pulses", 256'(start_cnt - start_base), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Sits directly upstream of the golden comparator in the matrix-multiply verification environment.
- Captures result rows streamed out of the DUT over a valid/ready channel.
- Assembles them into the hardware result matrix the comparator reads, then issues a one-cycle start-compare pulse.
- Adds dimension checking, row/last consistency checking and a stall timeout, so a hung or misbehaving DUT is flagged instead of blocking the bench.

Parameters:
BW, 64, stream beat width in bits
DW, 16, element width in bits
MAX_DIM, BW/DW (4), maximum rows/columns; one beat carries one row of MAX_DIM elements
TIMEOUT_CYC, 1000, consecutive stalled COLLECT cycles before abort; 0 disables the timeout

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
arm  input  1  one-cycle request to start a collection; latches n_dim/m_dim
n_dim  input  $clog2(MAX_DIM)+1  row count N, legal range 1..MAX_DIM
m_dim  input  $clog2(MAX_DIM)+1  column count M, legal range 1..MAX_DIM
in_valid  input  1  result beat valid
in_data  input  BW  result row; element j at bits [j*DW +: DW]
in_last  input  1  DUT marks final row
in_ready  output  1  collector accepts a beat
mat_res_flat  output  MAX_DIM*MAX_DIM*DW  element [i][j] at bits [(i*MAX_DIM+j)*DW +: DW]
start_cmp  output  1  one-cycle pulse: matrix complete and stable
busy  output  1  state is COLLECT or CMP
done  output  1  state is DONE
dim_err  output  1  sticky: illegal dimensions on arm
last_err  output  1  sticky: in_last disagreed with row position
timeout_err  output  1  sticky: collection aborted by stall timeout

Behaviour:
- Reset (rst=1 at a clock edge) applies from any state, including mid-collection:
  - state=IDLE, row_cnt=0, stall_cnt=0.
  - mat_res_flat=0; all outputs and flags 0.
- States:
  - IDLE: waiting for arm.
  - COLLECT: accepting rows.
  - CMP: single cycle; start_cmp=1.
  - DONE: holding the completed matrix.
- Arm handling (accepted in IDLE, DONE or COLLECT):
  - Clear dim_err, last_err and timeout_err.
  - If n_dim or m_dim is 0 or greater than MAX_DIM: set dim_err=1, go to IDLE, leave the matrix untouched.
  - Otherwise: latch N and M, zero mat_res_flat, set row_cnt=0 and stall_cnt=0, go to COLLECT.
  - Arm during COLLECT aborts the current collection and restarts it. Any beat offered in the same cycle is not accepted, because in_ready is registered.
- in_ready:
  - Registered; equals 1 exactly while in COLLECT.
  - Arm at edge t gives in_ready=1 from t+1.
- Beat acceptance in COLLECT (in_valid & in_ready):
  - Row row_cnt, column j < M is written from in_data[j*DW +: DW].
  - Columns j >= M are written 0.
  - row_cnt increments; stall_cnt is cleared.
- in_last checking:
  - in_last=1 on a beat with row_cnt < N-1: last_err=1, collection continues.
  - in_last=0 on the row N-1 beat: last_err=1.
  - Completion is determined by the row count only; in_last never ends a collection.
- Completion:
  - Accepting row N-1 at edge t moves the state to CMP: start_cmp=1 and the matrix is final during t+1.
  - At t+2 the state is DONE: done=1, in_ready=0.
  - Matrix is held until the next arm or reset.
- Stall timeout:
  - Each COLLECT cycle without an accept increments stall_cnt.
  - When stall_cnt reaches TIMEOUT_CYC (and TIMEOUT_CYC != 0): go to IDLE, timeout_err=1, no start_cmp pulse. The partial matrix remains visible.
- start_cmp:
  - Never high outside CMP.
  - Exactly one pulse per successful collection.
- Values stored bit-exact; no arithmetic is performed on data.
- Beats offered while not in COLLECT are not accepted; there is no buffering.

Test Plan:
- Full-size collection:
  - Stimulus: arm with N=4, M=4; 4 beats, row i = {16'h(i*4+3), (i*4+2), (i*4+1), (i*4+0)}; in_last on row 3; in_valid held high.
  - Response: one beat per cycle; start_cmp single pulse one cycle after the 4th accept; mat[2][1]=9; done=1; no error flags.
- Partial width with stalls:
  - Stimulus: arm with N=2, M=3; in_data all 16'hFFFF; in_valid toggled 1,0,1.
  - Response: columns 0..2 = FFFF, column 3 = 0, rows 2..3 = 0; start_cmp fires after the 2nd accept.
- Illegal dimensions:
  - Stimulus: arm with n_dim=0, then arm with m_dim=5.
  - Response: dim_err=1 each time, state IDLE, in_ready stays 0, no start_cmp.
- in_last consistency:
  - Stimulus: N=3; in_last asserted on row 1; normal row 2 with in_last.
  - Response: last_err=1 after row 1; collection still completes after 3 beats with a start_cmp pulse.
  - Stimulus: next arm.
  - Response: last_err cleared.
- Timeout and reset mid-operation:
  - Stimulus: TIMEOUT_CYC=8; arm with N=4; send 1 beat, then in_valid=0.
  - Response: 8 cycles later state IDLE, timeout_err=1, no start_cmp, row 0 retained.
  - Stimulus: re-arm, send 2 beats, assert rst.
  - Response: the next cycle shows all outputs 0 and in_ready=0.
- Re-arm during COLLECT:
  - Stimulus: N=4 with 2 rows accepted; arm with N=1, M=1; then send one beat 16'h00AB.
  - Response: matrix zeroed except mat[0][0]=16'h00AB; exactly one start_cmp pulse.
